// File: rtl/pos_map_pkg.sv
// Shared map of the position-word RAM and the writer FSM encoding.
// Used by game_pos_writer (producer) and by the display-side loader (consumer).
// Contents: word addresses of the position block and sprite bases, the
// 2-bit writer state encoding, and a velocity sign-extension helper.
package pos_map_pkg;

  localparam logic [12:0] POS_BASE         = 13'd6144;
  localparam logic [12:0] POS_OFF_X        = 13'd0;
  localparam logic [12:0] POS_OFF_Y        = 13'd1;
  localparam logic [12:0] MAN_BASE_ADDR    = 13'd0;
  localparam logic [12:0] CACTUS_BASE_ADDR = 13'd4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_WR_X   = 2'd2,
    ST_WR_Y   = 2'd3
  } pos_state_e;

  // Widen an 8-bit signed velocity to the 17-bit signed Y arithmetic width.
  function automatic logic signed [16:0] sext_vel(input logic signed [7:0] v);
    return $signed({{9{v[7]}}, v});
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push button followed by a
// rising-edge detector producing a one-cycle pulse in the clk_i domain.
// Ports: clk_i clock, rst_i async active-high reset, btn_i raw button,
//        rise_o one-cycle pulse on each synchronised 0->1 transition.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchroniser chain and delayed copy for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/game_pos_writer.sv
// Producer side of the position-word RAM read by the VGA overlay.
// Each frame tick advances obstacle scroll and player jump physics, then
// writes obstacle_x to POS_BASE+0 and player_y to POS_BASE+1, stalling while
// the display loader holds rd_busy.
// Ports: sys_clk / reset (async, active-high); frame_tick pulse; jump_btn raw
//        button; rd_busy write hold-off; ram_addr/ram_wdata/ram_we write port;
//        obstacle_x, player_y, airborne game state; busy sequence active;
//        overrun_cnt saturating count of dropped ticks.
module game_pos_writer
  import pos_map_pkg::*;
#(
  parameter logic        [15:0] START_X  = 16'd400,
  parameter logic        [15:0] GROUND_Y = 16'd200,
  parameter logic        [15:0] SCREEN_W = 16'd640,
  parameter logic        [15:0] SPEED    = 16'd4,
  parameter logic signed [7:0]  JUMP_V   = 8'sd16,
  parameter logic signed [7:0]  GRAVITY  = 8'sd1
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump_btn,
  input  logic        rd_busy,
  output logic [12:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic [15:0] obstacle_x,
  output logic [15:0] player_y,
  output logic        airborne,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  pos_state_e         state_q, state_d;
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic signed [7:0]  vel_q, vel_d;
  logic               air_q, air_d;
  logic               pending_q, pending_d;
  logic               jump_req_q, jump_req_d;
  logic [7:0]         overrun_q, overrun_d;
  logic               jump_rise_s;

  // Physics intermediates: a jump start takes effect in the same UPDATE.
  logic               jump_start_s;
  logic signed [7:0]  vel_eff_s;
  logic signed [16:0] y_n_s;

  btn_sync_edge u_btn (
    .clk_i  (sys_clk),
    .rst_i  (reset),
    .btn_i  (jump_btn),
    .rise_o (jump_rise_s)
  );

  assign jump_start_s = ~air_q & jump_req_q;
  assign vel_eff_s    = jump_start_s ? -JUMP_V : vel_q;
  assign y_n_s        = $signed({1'b0, y_q}) + sext_vel(vel_eff_s);

  // State register and game state.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= START_X;
      y_q        <= GROUND_Y;
      vel_q      <= 8'sd0;
      air_q      <= 1'b0;
      pending_q  <= 1'b0;
      jump_req_q <= 1'b0;
      overrun_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      air_q      <= air_d;
      pending_q  <= pending_d;
      jump_req_q <= jump_req_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state, physics update, tick queueing and jump request bookkeeping.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    air_d      = air_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    jump_req_d = jump_req_q;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick || pending_q) begin
          state_d   = ST_UPDATE;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        state_d = ST_WR_X;
        x_d     = (x_q >= SPEED) ? (x_q - SPEED) : SCREEN_W;
        if (air_q || jump_start_s) begin
          air_d = 1'b1;
          if (y_n_s[16]) begin
            y_d   = 16'd0;
            vel_d = 8'sd0;
          end else if ((vel_eff_s > 8'sd0) && (y_n_s >= $signed({1'b0, GROUND_Y}))) begin
            y_d   = GROUND_Y;
            vel_d = 8'sd0;
            air_d = 1'b0;
          end else begin
            y_d   = y_n_s[15:0];
            vel_d = vel_eff_s + GRAVITY;
          end
        end else begin
          air_d = 1'b0;
        end
      end
      ST_WR_X: begin
        if (!rd_busy) begin
          state_d = ST_WR_Y;
        end else begin
          state_d = ST_WR_X;
        end
      end
      ST_WR_Y: begin
        if (!rd_busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_Y;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A tick while a sequence runs is queued once; further ticks are dropped.
    if ((state_q != ST_IDLE) && frame_tick) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (overrun_q != 8'd255) begin
        overrun_d = overrun_q + 8'd1;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      overrun_d = overrun_q;
    end

    // A new press wins over the UPDATE clear so it survives to the next frame.
    if (jump_rise_s) begin
      jump_req_d = 1'b1;
    end else if (state_q == ST_UPDATE) begin
      jump_req_d = 1'b0;
    end else begin
      jump_req_d = jump_req_q;
    end
  end

  // Write port: driven only from write states and only when the loader is idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = 13'd0;
    ram_wdata = 16'd0;
    case (state_q)
      ST_WR_X: begin
        ram_we    = ~rd_busy;
        ram_addr  = POS_BASE + POS_OFF_X;
        ram_wdata = x_q;
      end
      ST_WR_Y: begin
        ram_we    = ~rd_busy;
        ram_addr  = POS_BASE + POS_OFF_Y;
        ram_wdata = y_q;
      end
      default: begin
        ram_we    = 1'b0;
        ram_addr  = 13'd0;
        ram_wdata = 16'd0;
      end
    endcase
  end

  assign obstacle_x  = x_q;
  assign player_y    = y_q;
  assign airborne    = air_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun_cnt = overrun_q;

endmodule

// File: doc/game_pos_writer.md
Name: game_pos_writer

Overview:
- Producer side of the position-word RAM that the VGA overlay reads at vertical blank.
- Once per frame tick, advances the obstacle scroll and the player jump physics.
- Writes obstacle_x to word POS_BASE+0 and player_y to word POS_BASE+1 through a single write port.
- Never drives the port while the display-side loader asserts rd_busy.

Parameters:
- POS_BASE, 13'd6144, word address of the position block (X at +0, Y at +1).
- START_X, 16'd400, obstacle_x after reset.
- GROUND_Y, 16'd200, player_y when grounded.
- SCREEN_W, 16'd640, obstacle_x reload value on wrap.
- SPEED, 16'd4, obstacle pixels per frame.
- JUMP_V, 8'sd16, initial upward speed (velocity set to -JUMP_V).
- GRAVITY, 8'sd1, velocity increment per frame.

Ports:
- sys_clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame (sys_clk domain).
- jump_btn  in  1  raw asynchronous button, active-high.
- rd_busy  in  1  display loader is reading the position words; writes are held off.
- ram_addr  out  13  write address.
- ram_wdata  out  16  write data.
- ram_we  out  1  write strobe, one cycle per word.
- obstacle_x  out  16  current obstacle X.
- player_y  out  16  current player Y.
- airborne  out  1  player is mid-jump.
- busy  out  1  update/write sequence in progress.
- overrun_cnt  out  8  count of dropped frame ticks, saturating.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock sys_clk.
- Reset values:
  - ram_we=0, ram_addr=0, ram_wdata=0.
  - obstacle_x=START_X, player_y=GROUND_Y, vel=0, airborne=0.
  - busy=0, overrun_cnt=0; pending, jump_req and the synchroniser all cleared.
- No write occurs until the first tick.
- FSM states: IDLE, UPDATE, WR_X, WR_Y.
- IDLE:
  - If frame_tick or pending is set, go to UPDATE and clear pending.
- UPDATE (1 cycle): compute and register the new state.
  - obstacle_x: if obstacle_x >= SPEED then obstacle_x - SPEED, else SCREEN_W.
  - If not airborne and jump_req: vel=-JUMP_V, airborne=1, and the y step is applied in this same UPDATE.
  - If airborne: y_n = player_y + sext(vel) in 17-bit signed; vel += GRAVITY.
    - If y_n < 0: player_y=0, vel=0.
    - Else if vel before the add was > 0 and y_n >= GROUND_Y: player_y=GROUND_Y, vel=0, airborne=0 (landing).
    - Else player_y = y_n.
  - jump_req is cleared in every UPDATE, whether consumed or not. A press while airborne is discarded.
- WR_X:
  - While rd_busy=1: hold with ram_we=0.
  - Else one cycle of ram_we=1, ram_addr=POS_BASE, ram_wdata=new obstacle_x, then go to WR_Y.
- WR_Y:
  - Same stall rule as WR_X.
  - Writes POS_BASE+1 with the new player_y, then returns to IDLE.
- Latency: with a tick at cycle N and rd_busy low, UPDATE runs at N+1, X is written at N+2, Y at N+3, and the FSM is back in IDLE at N+4.
- busy is high in every state except IDLE.
- Tick outside IDLE:
  - If pending=0, set pending=1 (one-deep queue).
  - If pending=1, drop the tick and increment overrun_cnt, saturating at 255.
  - A tick in the same cycle IDLE exits is consumed by that exit and does not set pending.
- jump_btn path:
  - 2-FF synchroniser, then rising-edge detect; the edge sets jump_req.
  - An edge in the same cycle as UPDATE's clear is kept for the next frame (set wins).
- Both words are written in the same sequence and always from the same UPDATE, so no torn pair is produced.
- Reset mid-sequence: ram_we drops immediately, FSM returns to IDLE, and no partial-sequence write occurs.

Decomposition:
- Package pos_map_pkg holds:
  - POS_BASE, POS_OFF_X=0, POS_OFF_Y=1;
  - MAN_BASE_ADDR=0 and CACTUS_BASE_ADDR=4096;
  - FSM state encoding (2-bit).
  The display-side loader shares this package.
- One sub-module, btn_sync_edge: 2-FF synchroniser plus rising-edge pulse, with async reset.

Test Plan:
1. Reset, then a single tick with rd_busy=0 -> ram_we at N+2 (addr 6144, data 396) and N+3 (addr 6145, data 200); busy high N+1..N+3; airborne=0.
2. Press jump_btn, then tick -> Y written as 184 and airborne=1. After 16 ticks Y=64. On the 33rd tick Y=200 exactly and airborne drops to 0.
3. Wrap: ticks until X=4 -> next write is 0, following write is 640, then 636.
4. Hold rd_busy=1 for 10 cycles starting at N+2 -> no ram_we while high; X written on the first cycle rd_busy=0, Y the next cycle; values unchanged.
5. Three ticks 1 cycle apart starting at N -> second tick sets pending, third increments overrun_cnt to 1; exactly two write pairs occur.
6. Assert reset during WR_X -> ram_we=0 in the same cycle; outputs return to 400/200/0; a subsequent tick writes 396.
